// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sound_pkg
//  Description : Shared constants and helpers for the sound-path I2S blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package sound_pkg;

  // Nominal I2S framing used by the sound transmitter: 128 bclk per channel.
  localparam int I2S_SLOTS_PER_CH = 128;
  localparam int I2S_FRAME_BCLKS  = 2 * I2S_SLOTS_PER_CH;

  // Standard I2S: the MSB follows the lrck edge by one bclk.
  localparam int I2S_DELAY_SLOTS  = 1;

  // lrck level identifies the channel currently on the wire.
  typedef enum logic {
    I2S_CH_LEFT  = 1'b0,
    I2S_CH_RIGHT = 1'b1
  } i2s_ch_e;

  // Slot counter needs one extra bit so an over-long half saturates well
  // above the nominal length instead of wrapping back into range.
  function automatic int i2s_slot_cnt_width(input int slots);
    return $clog2(slots) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_sync
//  Description : Two-flop synchronizers for the asynchronous I2S pins plus a
//                rising-edge detector on the synchronized bit clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i2s_bclk,
  input  logic i2s_lrck,
  input  logic i2s_dat,
  output logic bclk_rise,
  output logic lrck_s,
  output logic dat_s
);

  logic [1:0] r_bclk_sync;
  logic [1:0] r_lrck_sync;
  logic [1:0] r_dat_sync;
  logic       r_bclk_prev;

  // Resynchronize all three pins and keep one history bit of bclk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bclk_sync <= 2'b00;
      r_lrck_sync <= 2'b00;
      r_dat_sync  <= 2'b00;
      r_bclk_prev <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[0], i2s_bclk};
      r_lrck_sync <= {r_lrck_sync[0], i2s_lrck};
      r_dat_sync  <= {r_dat_sync[0],  i2s_dat};
      r_bclk_prev <= r_bclk_sync[1];
    end
  end

  assign bclk_rise = r_bclk_sync[1] & ~r_bclk_prev;
  assign lrck_s    = r_lrck_sync[1];
  assign dat_s     = r_dat_sync[1];

endmodule
`default_nettype wire

// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx
//  Description : Oversampling I2S receiver. Deserializes one WIDTH-bit word
//                per channel, checks half-frame length, tracks lock and a
//                stalled bit clock, and presents stereo samples with a strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx
  import sound_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int SLOTS_PER_CH = I2S_SLOTS_PER_CH,
  parameter int TIMEOUT      = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i2s_bclk,
  input  logic             i2s_lrck,
  input  logic             i2s_dat,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic             sample_valid,
  output logic             frame_err,
  output logic             locked
);

  localparam int C_SLOT_W = i2s_slot_cnt_width(SLOTS_PER_CH);
  localparam int C_IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [C_SLOT_W-1:0] C_SLOT_MAX   = '1;
  localparam logic [C_SLOT_W-1:0] C_FIRST_SLOT = C_SLOT_W'(I2S_DELAY_SLOTS);
  localparam logic [C_SLOT_W-1:0] C_LAST_SLOT  = C_SLOT_W'(I2S_DELAY_SLOTS + WIDTH - 1);
  localparam logic [C_SLOT_W:0]   C_HALF_LEN   = (C_SLOT_W + 1)'(SLOTS_PER_CH);
  localparam logic [C_IDLE_W-1:0] C_IDLE_LAST  = C_IDLE_W'(TIMEOUT - 1);
  localparam logic [C_IDLE_W-1:0] C_IDLE_MAX   = C_IDLE_W'(TIMEOUT);

  logic                w_bclk_rise;
  logic                w_lrck;
  logic                w_dat;
  logic                w_lrck_edge;
  logic                w_timeout;
  logic                w_in_word;
  logic [C_SLOT_W-1:0] w_slot_next;
  logic [C_SLOT_W:0]   w_len;
  logic [WIDTH-1:0]    w_word;

  logic                r_lrck_last;
  logic [C_SLOT_W-1:0] r_slot_cnt;
  logic [WIDTH-2:0]    r_shreg;
  logic [WIDTH-1:0]    r_hold_l;
  logic                r_ok_l;
  logic                r_seen;
  logic [1:0]          r_good;
  logic [C_IDLE_W-1:0] r_idle;

  i2s_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_dat   (i2s_dat),
    .bclk_rise (w_bclk_rise),
    .lrck_s    (w_lrck),
    .dat_s     (w_dat)
  );

  // An lrck change seen at a bclk rise marks slot 0 of a new half.
  assign w_lrck_edge = w_bclk_rise & (w_lrck != r_lrck_last);
  // Length of the half that ends at this edge.
  assign w_len       = {1'b0, r_slot_cnt} + (C_SLOT_W + 1)'(1);
  assign w_slot_next = (r_slot_cnt == C_SLOT_MAX) ? r_slot_cnt
                                                  : r_slot_cnt + C_SLOT_W'(1);
  assign w_in_word   = (w_slot_next >= C_FIRST_SLOT) && (w_slot_next <= C_LAST_SLOT);
  // Complete word as it stands once the current bit is appended.
  assign w_word      = {r_shreg, w_dat};
  assign w_timeout   = ~w_bclk_rise & (r_idle == C_IDLE_LAST);

  // Slot counting and serial-to-parallel shifting, advanced on each bclk rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lrck_last <= 1'b0;
      r_slot_cnt  <= '0;
      r_shreg     <= '0;
    end else if (w_bclk_rise) begin
      r_lrck_last <= w_lrck;
      if (w_lrck != r_lrck_last) begin
        r_slot_cnt <= '0;
      end else begin
        r_slot_cnt <= w_slot_next;
        if (w_in_word) begin
          r_shreg <= w_word[WIDTH-2:0];
        end
      end
    end
  end

  // Idle watchdog: clk cycles since the last bclk rise, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (w_bclk_rise) begin
      r_idle <= '0;
    end else if (r_idle != C_IDLE_MAX) begin
      r_idle <= r_idle + C_IDLE_W'(1);
    end
  end

  // Lock tracking, word capture and output presentation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
      r_hold_l     <= '0;
      r_ok_l       <= 1'b0;
      r_seen       <= 1'b0;
      r_good       <= 2'd0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (w_timeout) begin
        // Stalled bit clock: start over without reporting a framing error.
        locked <= 1'b0;
        r_good <= 2'd0;
        r_seen <= 1'b0;
      end else if (w_lrck_edge) begin
        // A new left half invalidates the previously held left word.
        if (w_lrck == I2S_CH_LEFT) begin
          r_ok_l <= 1'b0;
        end
        if (!r_seen) begin
          r_seen <= 1'b1;
        end else if (w_len != C_HALF_LEN) begin
          frame_err <= 1'b1;
          locked    <= 1'b0;
          r_good    <= 2'd0;
        end else begin
          if (r_good != 2'd2) begin
            r_good <= r_good + 2'd1;
          end
          if (r_good != 2'd0) begin
            locked <= 1'b1;
          end
        end
      end else if (w_bclk_rise && (w_slot_next == C_LAST_SLOT)) begin
        if (w_lrck == I2S_CH_LEFT) begin
          r_hold_l <= w_word;
          r_ok_l   <= 1'b1;
        end else if (locked && r_ok_l) begin
          left         <= r_hold_l;
          right        <= w_word;
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_rx
//  Description : Self-checking bench for i2s_rx with a half-frame level
//                reference model and randomized word/length stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_rx;

  localparam int W         = 16;
  localparam int SLOTS     = 128;
  localparam int TMO       = 1024;
  localparam int CLK_P     = 10;
  localparam int BCLK_HALF = 20;   // bclk = clk / 4

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic i2s_bclk = 1'b0;
  logic i2s_lrck = 1'b0;
  logic i2s_dat  = 1'b0;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic sample_valid;
  logic frame_err;
  logic locked;

  i2s_rx #(.WIDTH(W), .SLOTS_PER_CH(SLOTS), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_dat      (i2s_dat),
    .left         (left),
    .right        (right),
    .sample_valid (sample_valid),
    .frame_err    (frame_err),
    .locked       (locked)
  );

  always #(CLK_P/2) clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observed side: strobe counts and captured samples.
  longint          cyc = 0;
  int              dut_sv_cnt  = 0;
  int              dut_err_cnt = 0;
  logic [2*W-1:0]  dut_q[$];
  longint          sv_stamp[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      dut_sv_cnt++;
      dut_q.push_back({left, right});
      sv_stamp.push_back(cyc);
    end
    if (frame_err === 1'b1) dut_err_cnt++;
  end

  // Reference model, advanced one whole half-frame at a time.
  bit             m_last_lr = 1'b0;
  bit             m_seen    = 1'b0;
  bit             m_locked  = 1'b0;
  bit             m_okl     = 1'b0;
  int             m_good    = 0;
  int             m_cur_len = 0;
  logic [W-1:0]   m_hold_l  = '0;
  logic [W-1:0]   m_left    = '0;
  logic [W-1:0]   m_right   = '0;
  int             m_sv_cnt  = 0;
  int             m_err_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  function automatic void model_half(input bit lr, input int len, input logic [W-1:0] word);
    if (lr != m_last_lr) begin
      if (!m_seen) begin
        m_seen = 1'b1;
      end else if (m_cur_len != SLOTS) begin
        m_err_cnt++;
        m_locked = 1'b0;
        m_good   = 0;
      end else begin
        if (m_good < 2) m_good++;
        if (m_good == 2) m_locked = 1'b1;
      end
      m_last_lr = lr;
      m_cur_len = len;
      if (!lr) m_okl = 1'b0;
    end else begin
      m_cur_len += len;
    end
    // Word occupies slots 1..W, so the half must reach slot W.
    if (len >= W + 1) begin
      if (!lr) begin
        m_hold_l = word;
        m_okl    = 1'b1;
      end else if (m_locked && m_okl) begin
        m_left  = m_hold_l;
        m_right = word;
        m_sv_cnt++;
        exp_q.push_back({m_left, m_right});
      end
    end
  endfunction

  function automatic void model_reset();
    m_last_lr = 1'b0; m_seen = 1'b0; m_locked = 1'b0; m_okl = 1'b0;
    m_good = 0; m_cur_len = 0; m_hold_l = '0; m_left = '0; m_right = '0;
  endfunction

  function automatic void model_timeout();
    m_seen = 1'b0; m_good = 0; m_locked = 1'b0;
  endfunction

  // Drive one half-frame: lrck/dat change on the bclk falling edge.
  task automatic send_half(input bit lr, input int len, input logic [W-1:0] word);
    model_half(lr, len, word);
    for (int s = 0; s < len; s++) begin
      i2s_bclk = 1'b0;
      i2s_lrck = lr;
      i2s_dat  = (s >= 1 && s <= W) ? word[W-s] : 1'($urandom);
      #(BCLK_HALF);
      i2s_bclk = 1'b1;
      #(BCLK_HALF);
    end
  endtask

  task automatic checkpoint(input string tag);
    logic [2*W-1:0] e;
    logic [2*W-1:0] a;
    repeat (8) @(negedge clk);
    check_eq({tag, " locked"},    32'(locked),      32'(m_locked));
    check_eq({tag, " sv_count"},  32'(dut_sv_cnt),  32'(m_sv_cnt));
    check_eq({tag, " err_count"}, 32'(dut_err_cnt), 32'(m_err_cnt));
    while (exp_q.size() > 0 && dut_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_q.pop_front();
      check_eq({tag, " sample_left"},  32'(a[2*W-1:W]), 32'(e[2*W-1:W]));
      check_eq({tag, " sample_right"}, 32'(a[W-1:0]),   32'(e[W-1:0]));
    end
    exp_q.delete();
    dut_q.delete();
    check_eq({tag, " left_now"},  32'(left),  32'(m_left));
    check_eq({tag, " right_now"}, 32'(right), 32'(m_right));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " left"},         32'(left),         32'h0);
    check_eq({tag, " right"},        32'(right),        32'h0);
    check_eq({tag, " sample_valid"}, 32'(sample_valid), 32'h0);
    check_eq({tag, " frame_err"},    32'(frame_err),    32'h0);
    check_eq({tag, " locked"},       32'(locked),       32'h0);
  endtask

  initial begin
    #(2ms);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w_tx;
    logic [W-1:0] wa;
    logic [W-1:0] wb;
    int           len;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #2;

    // 1: transmitter-style word, 14-bit magnitude framed by zero slots
    w_tx = {1'b0, 14'h2AAA, 1'b0};
    send_half(1'b1, SLOTS, w_tx); checkpoint("t1 edge1");
    send_half(1'b0, SLOTS, w_tx); checkpoint("t1 edge2");
    send_half(1'b1, SLOTS, w_tx); checkpoint("t1 edge3");
    for (int f = 0; f < 2; f++) begin
      send_half(1'b0, SLOTS, w_tx);
      send_half(1'b1, SLOTS, w_tx);
    end
    checkpoint("t1 run");
    check_eq("t1 left_value",  32'(left),  32'h5554);
    check_eq("t1 right_value", 32'(right), 32'h5554);

    // 2: extreme-pattern words, sample period must be one frame
    sv_stamp.delete();
    for (int f = 0; f < 4; f++) begin
      send_half(1'b0, SLOTS, 16'h8001);
      send_half(1'b1, SLOTS, 16'h7FFE);
    end
    checkpoint("t2");
    check_eq("t2 left_value",  32'(left),  32'h8001);
    check_eq("t2 right_value", 32'(right), 32'h7FFE);
    check_eq("t2 pulses", 32'(sv_stamp.size()), 32'd4);
    for (int i = 1; i < sv_stamp.size(); i++)
      check_eq("t2 period", 32'(sv_stamp[i] - sv_stamp[i-1]),
               32'(2 * SLOTS * 2 * BCLK_HALF / CLK_P));

    // 3: short left half
    wa = 16'($urandom); wb = 16'($urandom);
    send_half(1'b0, 100, wa);   checkpoint("t3 short");
    send_half(1'b1, SLOTS, wb); checkpoint("t3 err");
    wa = 16'($urandom); wb = 16'($urandom);
    send_half(1'b0, SLOTS, wa);
    send_half(1'b1, SLOTS, wb); checkpoint("t3 relock");

    // 4: bit clock stall
    repeat (1100) @(negedge clk);
    model_timeout();
    checkpoint("t4 stall");
    for (int f = 0; f < 2; f++) begin
      send_half(1'b0, SLOTS, 16'($urandom));
      send_half(1'b1, SLOTS, 16'($urandom));
    end
    checkpoint("t4 relock");

    // 5: reset in the middle of a right half
    send_half(1'b0, SLOTS, 16'($urandom));
    send_half(1'b1, 50, 16'($urandom));
    checkpoint("t5 pre");
    #(BCLK_HALF);
    i2s_bclk = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("t5 reset");
    model_reset();
    repeat (3) @(negedge clk);
    send_half(1'b1, SLOTS - 50, 16'($urandom));
    for (int f = 0; f < 2; f++) begin
      send_half(1'b0, SLOTS, 16'($urandom));
      send_half(1'b1, SLOTS, 16'($urandom));
    end
    checkpoint("t5 relock");

    // 6: over-long right half saturates the slot counter
    send_half(1'b0, SLOTS, 16'($urandom));
    send_half(1'b1, 300, 16'($urandom));
    send_half(1'b0, SLOTS, 16'($urandom));
    checkpoint("t6 err");
    send_half(1'b1, SLOTS, 16'($urandom));
    send_half(1'b0, SLOTS, 16'($urandom));
    send_half(1'b1, SLOTS, 16'($urandom));
    checkpoint("t6 relock");

    // 7: random words with occasional bad half lengths
    for (int h = 0; h < 16; h++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 200)) : SLOTS;
      send_half(1'(h % 2), len, 16'($urandom));
    end
    checkpoint("t7 random");
    for (int f = 0; f < 2; f++) begin
      send_half(1'b0, SLOTS, 16'($urandom));
      send_half(1'b1, SLOTS, 16'($urandom));
    end
    checkpoint("t7 settle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
